// File: rtl/rotl_seq_16.sv
// Multi-cycle 16-bit left rotate / logical-left-shift unit.
// One log-shifter stage (by 1, 2, 4, 8) per clock; result held until accepted.
module rotl_seq_16 #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  input  logic        Mode,
  output logic [15:0] Shift_Out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  amt_q, amt_d;
  logic        mode_q, mode_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;

  logic [15:0] stage_rol;
  logic [15:0] stage_sll;

  // Shift by 2^cnt_q; only one of the four fixed-distance paths is selected per cycle.
  always_comb begin
    stage_rol = data_q;
    stage_sll = data_q;
    unique case (cnt_q)
      2'd0: begin
        stage_rol = {data_q[14:0], data_q[15]};
        stage_sll = {data_q[14:0], 1'b0};
      end
      2'd1: begin
        stage_rol = {data_q[13:0], data_q[15:14]};
        stage_sll = {data_q[13:0], 2'b00};
      end
      2'd2: begin
        stage_rol = {data_q[11:0], data_q[15:12]};
        stage_sll = {data_q[11:0], 4'h0};
      end
      2'd3: begin
        stage_rol = {data_q[7:0], data_q[15:8]};
        stage_sll = {data_q[7:0], 8'h00};
      end
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = Shift_In;
          amt_d   = Shift_Val;
          mode_d  = Mode;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (amt_q[cnt_q]) data_d = mode_q ? stage_sll : stage_rol;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          res_d   = data_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Shift_Out = res_q;

endmodule

// File: tb/tb_rotl_seq_16.sv
// Scoreboard bench for rotl_seq_16: driver pushes expected results at accept,
// monitor pops and compares when out_valid rises.
module tb_rotl_seq_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic        Mode;
  logic [15:0] Shift_Out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  rotl_seq_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .Shift_Out (Shift_Out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input int n, input logic m);
    longint unsigned v;
    v = longint'(x);
    if (m) return 16'((v << n) & 64'hFFFF);
    return 16'(((v << n) | (v >> (16 - n))) & 64'hFFFF);
  endfunction

  // Monitor: each rising out_valid delivers one result.
  always @(negedge clk) begin
    if (!rst && out_valid && !ov_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(Shift_Out), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(Shift_Out), 32'(e.res));
        check("latency", 32'(cyc - e.acc_cyc), 32'd4);
      end
    end
    ov_prev <= out_valid;
  end

  // Drive one request; returns at the negedge after the accept edge.
  task automatic issue(input logic [15:0] x, input logic [3:0] n, input logic m,
                       input logic [15:0] exp_res, input logic keep_valid, output int acc);
    int guard;
    @(negedge clk);
    Shift_In  = x;
    Shift_Val = n;
    Mode      = m;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    acc = cyc + 1;
    @(posedge clk);
    exp_q.push_back('{res: exp_res, acc_cyc: acc});
    @(negedge clk);
    in_valid = keep_valid;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int a0, a1;
    logic [15:0] x, hold;
    int guard;

    rst = 1'b1; in_valid = 1'b0; Shift_In = '0; Shift_Val = '0; Mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_shift_out", 32'(Shift_Out), 32'h0);
      @(negedge clk);
    end

    // Directed ROL and SLL vectors.
    issue(16'h8001, 4'd1,  1'b0, 16'h0003, 1'b0, a0); drain();
    issue(16'h1234, 4'd4,  1'b0, 16'h2341, 1'b0, a0); drain();
    issue(16'h8000, 4'd15, 1'b0, 16'h4000, 1'b0, a0); drain();
    issue(16'hABCD, 4'd0,  1'b0, 16'hABCD, 1'b0, a0); drain();
    issue(16'hFFFF, 4'd15, 1'b1, 16'h8000, 1'b0, a0); drain();
    issue(16'h00F1, 4'd8,  1'b1, 16'hF100, 1'b0, a0); drain();
    issue(16'h1234, 4'd0,  1'b1, 16'h1234, 1'b0, a0); drain();

    // Random data, every amount, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 16; n++) begin
        x = 16'($urandom);
        issue(x, 4'(n), 1'(m), model(x, n, 1'(m)), 1'b0, a0);
      end
    end
    drain();

    // Backpressure: result and flags hold while out_ready is low.
    out_ready = 1'b0;
    x = 16'($urandom);
    issue(x, 4'd5, 1'b0, model(x, 5, 1'b0), 1'b0, a0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    hold = model(x, 5, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("bp_shift_out", 32'(Shift_Out), 32'(hold));
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_ov", 32'(out_valid), 32'd0);
    issue(16'h0F0F, 4'd4, 1'b1, 16'hF0F0, 1'b0, a0);
    drain();

    // in_valid held high with changing operands during RUN/DONE.
    issue(16'h1357, 4'd3, 1'b0, model(16'h1357, 3, 1'b0), 1'b1, a0);
    for (int i = 0; i < 4; i++) begin
      Shift_In  = 16'($urandom);
      Shift_Val = 4'($urandom);
      Mode      = 1'($urandom);
      @(negedge clk);
    end
    issue(16'h2468, 4'd7, 1'b1, model(16'h2468, 7, 1'b1), 1'b0, a1);
    check("back_to_back_spacing", 32'(a1 - a0), 32'd6);
    drain();

    // Reset at E2 aborts the operation.
    issue(16'hBEEF, 4'd9, 1'b0, model(16'hBEEF, 9, 1'b0), 1'b0, a0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_shift_out", 32'(Shift_Out), 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    issue(16'h0001, 4'd3, 1'b0, 16'h0008, 1'b0, a0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
